// File: rtl/iter_alu_pkg.sv
// Shared definitions for iter_alu: opcode and FSM state encodings, status flag bit positions.
package iter_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_MUL   = 4'b1000,
        OP_MULHU = 4'b1001,
        OP_DIVU  = 4'b1010,
        OP_REMU  = 4'b1011
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/iter_alu_muldiv.sv
// Iterative engine: shift-add multiply and (with ITER_ALU_DIV_EN) restoring divide, one bit per cycle.
module iter_alu_muldiv
    import iter_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] cnt;
    logic [N-1:0]  hi, lo, opnd;
    logic [N-1:0]  hi_nxt, lo_nxt;
    logic [N:0]    mul_sum;
    logic          want_hi;
`ifdef ITER_ALU_DIV_EN
    logic          is_div;
    logic [N:0]    shifted, diff;
`endif

    // hi:lo is the product (hi accumulates, lo shifts out multiplier bits)
    // or, for division, the partial remainder and the dividend/quotient shifter.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_nxt  = mul_sum[N:1];
        lo_nxt  = {mul_sum[0], lo[N-1:1]};
`ifdef ITER_ALU_DIV_EN
        shifted = {hi, lo[N-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            hi_nxt = diff[N] ? shifted[N-1:0] : diff[N-1:0];
            lo_nxt = {lo[N-2:0], ~diff[N]};
        end
`endif
    end

    // The final iteration's values are forwarded so the result lands on the same edge.
    assign done   = (cnt == CW'(1));
    assign result = want_hi ? hi_nxt : lo_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            want_hi <= 1'b0;
`ifdef ITER_ALU_DIV_EN
            is_div  <= 1'b0;
`endif
        end else if (start) begin
            cnt     <= CW'(N);
            hi      <= '0;
`ifdef ITER_ALU_DIV_EN
            is_div  <= (op == OP_DIVU) || (op == OP_REMU);
            want_hi <= (op == OP_MULHU) || (op == OP_REMU);
            lo      <= ((op == OP_DIVU) || (op == OP_REMU)) ? a : b;
            opnd    <= ((op == OP_DIVU) || (op == OP_REMU)) ? b : a;
`else
            want_hi <= (op == OP_MULHU);
            lo      <= b;
            opnd    <= a;
`endif
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_nxt;
            lo  <= lo_nxt;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: FSM, single-cycle ops, flags and output registers.
// Define ITER_ALU_DIV_EN to enable DIVU/REMU; otherwise those opcodes are illegal.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   status,
    output logic         err
);

    state_e       state;
    logic [N:0]   add_w, sub_w;
    logic [N-1:0] sc_res, md_res;
    logic         sc_c, sc_v, sc_err, iter, start, md_done;

    function automatic logic [3:0] make_flags(input logic [N-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f[FLAG_N] = r[N-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        iter   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res = add_w[N-1:0];
                sc_c   = add_w[N];
                sc_v   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[N-1:0];
                sc_c   = sub_w[N];
                sc_v   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLT:  sc_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res = {{(N-1){1'b0}}, a < b};
            OP_MUL, OP_MULHU: iter = 1'b1;
`ifdef ITER_ALU_DIV_EN
            // Divide by zero resolves immediately without entering CALC.
            OP_DIVU: if (b == '0) sc_res = '1; else iter = 1'b1;
            OP_REMU: if (b == '0) sc_res = a;  else iter = 1'b1;
`endif
            default: sc_err = 1'b1;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign start     = in_valid && (state == IDLE) && iter;

    iter_alu_muldiv #(.N(N)) u_muldiv (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (opcode),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_res)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            result <= '0;
            status <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (iter) begin
                        state <= CALC;
                    end else begin
                        state  <= DONE;
                        result <= sc_res;
                        status <= make_flags(sc_res, sc_c, sc_v);
                        err    <= sc_err;
                    end
                end
                CALC: if (md_done) begin
                    state  <= DONE;
                    result <= md_res;
                    status <= make_flags(md_res, 1'b0, 1'b0);
                    err    <= 1'b0;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu at N=32 and N=8 against an arithmetic reference model.
module tb_iter_alu;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  s;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iv[2], ir[2], ov[2], ordy[2], er[2];
    logic [3:0]  op_s[2], st[2];
    logic [31:0] a_s[2], b_s[2];
    logic [31:0] res32;
    logic [7:0]  res8;
    exp_t        q0[$], q1[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    iter_alu #(.N(32)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0]), .b(b_s[0]), .opcode(op_s[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .result(res32), .status(st[0]), .err(er[0])
    );

    iter_alu #(.N(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .opcode(op_s[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .result(res8), .status(st[1]), .err(er[1])
    );

    function automatic logic [31:0] get_res(input int k);
        return (k == 0) ? res32 : {24'h0, res8};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned x, input int n);
        return x[n-1] ? longint'(x) - (longint'(1) << n) : longint'(x);
    endfunction

    // Reference: what each opcode must produce, from plain integer arithmetic.
    task automatic model(input int n, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [3:0] s, output logic e, output int lat);
        longint unsigned mask = (64'd1 << n) - 1;
        longint unsigned au = x & mask;
        longint unsigned bu = y & mask;
        longint          smax = (longint'(1) << (n - 1)) - 1;
        longint          smin = -(longint'(1) << (n - 1));
        longint          sv;
        longint unsigned v64 = 0;
        logic c = 0, v = 0;
        e = 0;
        lat = 1;
        case (op)
            4'h0: begin v64 = au + bu; c = v64[n]; sv = sx(au, n) + sx(bu, n); v = (sv > smax) || (sv < smin); end
            4'h1: begin v64 = au - bu; c = (au < bu); sv = sx(au, n) - sx(bu, n); v = (sv > smax) || (sv < smin); end
            4'h2: v64 = au & bu;
            4'h3: v64 = au | bu;
            4'h4: v64 = au ^ bu;
            4'h5: v64 = (sx(au, n) < sx(bu, n)) ? 1 : 0;
            4'h6: v64 = (au < bu) ? 1 : 0;
            4'h8: begin v64 = au * bu; lat = n + 1; end
            4'h9: begin v64 = (au * bu) >> n; lat = n + 1; end
`ifdef ITER_ALU_DIV_EN
            4'hA: if (bu == 0) v64 = mask; else begin v64 = au / bu; lat = n + 1; end
            4'hB: if (bu == 0) v64 = au;   else begin v64 = au % bu; lat = n + 1; end
`endif
            default: begin v64 = 0; e = 1; end
        endcase
        r = 32'(v64 & mask);
        s = {r[n-1], r == 0, c, v};
    endtask

    // Compare process: whenever a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ov[k]) begin
                if (((k == 0) ? q0.size() : q1.size()) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid dut%0d: got 1, expected 0", k);
                end else begin
                    cur = (k == 0) ? q0[0] : q1[0];
                    check_val((k == 0) ? "result_n32" : "result_n8", get_res(k), cur.r);
                    check_val((k == 0) ? "status_n32" : "status_n8", {28'h0, st[k]}, {28'h0, cur.s});
                    check_val((k == 0) ? "err_n32" : "err_n8", {31'h0, er[k]}, {31'h0, cur.e});
                end
            end
        end
    end

    task automatic run_op(input int k, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int hold, input bit poke);
        logic [31:0] r;
        logic [3:0]  s;
        logic        e;
        int          lat, cnt;
        bit          busy_seen;
        exp_t        ex;
        model((k == 0) ? 32 : 8, op, x, y, r, s, e, lat);
        @(negedge clk);
        iv[k] = 1'b1; op_s[k] = op; a_s[k] = x; b_s[k] = y;
        cnt = 0;
        while (!ir[k] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!ir[k]) begin
            check_val("ready_timeout", {31'h0, ir[k]}, 32'd1);
            iv[k] = 1'b0;
            return;
        end
        @(posedge clk);
        ex.r = r; ex.s = s; ex.e = e;
        if (k == 0) q0.push_back(ex); else q1.push_back(ex);
        #1;
        // Operands change after accept; with poke a new request is held while busy.
        iv[k] = poke; a_s[k] = ~x; b_s[k] = x ^ y; op_s[k] = 4'h0;
        cnt = 0;
        busy_seen = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (ov[k]) break;
            if (ir[k]) busy_seen = 1;
        end
        check_val("latency", cnt, lat);
        check_val("ready_low_while_busy", {31'h0, busy_seen}, 32'd0);
        if (ov[k]) begin
            repeat (hold) begin
                @(negedge clk);
                check_val("no_accept_in_done", {31'h0, ir[k]}, 32'd0);
            end
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic run_suite(input int k);
        run_op(k, 4'h0, 32'h7FFFFFFF, 32'h1, 0, 0);
        run_op(k, 4'h0, 32'h0000007F, 32'h1, 0, 0);
        run_op(k, 4'h0, 32'hFFFFFFFF, 32'h1, 0, 0);
        run_op(k, 4'h1, 32'h0, 32'h1, 0, 0);
        run_op(k, 4'h1, 32'h80000000, 32'h1, 0, 0);
        run_op(k, 4'h1, 32'h00000080, 32'h1, 0, 0);
        run_op(k, 4'h2, 32'hF0F0A5A5, 32'hFF00C3C3, 0, 0);
        run_op(k, 4'h3, 32'hF0F0A5A5, 32'h0F00C3C3, 0, 0);
        run_op(k, 4'h4, 32'hF0F0A5A5, 32'hF0F0A5A5, 0, 0);
        run_op(k, 4'h5, 32'hFFFFFFFF, 32'h1, 0, 0);
        run_op(k, 4'h6, 32'hFFFFFFFF, 32'h1, 0, 0);
        run_op(k, 4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        run_op(k, 4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        run_op(k, 4'h8, 32'h00012345, 32'h00006789, 0, 0);
        run_op(k, 4'h9, 32'h80000080, 32'h00000003, 0, 0);
        run_op(k, 4'hA, 32'd100, 32'd7, 0, 0);
        run_op(k, 4'hB, 32'd100, 32'd7, 0, 0);
        run_op(k, 4'hA, 32'd1234, 32'd0, 0, 0);
        run_op(k, 4'hB, 32'd5, 32'd0, 0, 0);
        run_op(k, 4'hF, 32'h12345678, 32'h1, 0, 0);
        run_op(k, 4'h7, 32'h1, 32'h1, 0, 0);
        run_op(k, 4'h0, 32'h00000003, 32'h00000004, 5, 1);
        run_op(k, 4'h8, 32'h00000007, 32'h00000006, 5, 1);
    endtask

    task automatic pin(input string name, input int n, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er_, input logic [3:0] es, input logic ee, input int el);
        logic [31:0] r;
        logic [3:0]  s;
        logic        e;
        int          lat;
        model(n, op, x, y, r, s, e, lat);
        check_val({name, "_r"}, r, er_);
        check_val({name, "_s"}, {28'h0, s}, {28'h0, es});
        check_val({name, "_e"}, {31'h0, e}, {31'h0, ee});
        check_val({name, "_lat"}, lat, el);
    endtask

    initial begin
        bit seen;
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 0; ordy[k] = 0; op_s[k] = 0; a_s[k] = 0; b_s[k] = 0;
        end

        pin("m_add", 32, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 1'b0, 1);
        pin("m_sub", 32, 4'h1, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b1010, 1'b0, 1);
        pin("m_slt", 32, 4'h5, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000, 1'b0, 1);
        pin("m_sltu", 32, 4'h6, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0100, 1'b0, 1);
        pin("m_mulhu", 32, 4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 1'b0, 33);
        pin("m_mul", 32, 4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0000, 1'b0, 33);
        pin("m_ill", 32, 4'hF, 32'h5, 32'h6, 32'h0, 4'b0100, 1'b1, 1);
        pin("m_add8", 8, 4'h0, 32'h7F, 32'h1, 32'h80, 4'b1001, 1'b0, 1);
`ifdef ITER_ALU_DIV_EN
        pin("m_divu", 32, 4'hA, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0, 33);
        pin("m_remu", 32, 4'hB, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0, 33);
        pin("m_div0", 32, 4'hA, 32'd9, 32'd0, 32'hFFFFFFFF, 4'b1000, 1'b0, 1);
        pin("m_rem0", 32, 4'hB, 32'd5, 32'd0, 32'd5, 4'b0000, 1'b0, 1);
`else
        pin("m_divu_ill", 32, 4'hA, 32'd100, 32'd7, 32'd0, 4'b0100, 1'b1, 1);
`endif

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_val("rst_out_valid", {31'h0, ov[k]}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_val("rst_in_ready", {31'h0, ir[k]}, 32'd1);
            check_val("rst_out_valid", {31'h0, ov[k]}, 32'd0);
            check_val("rst_result", get_res(k), 32'd0);
            check_val("rst_status", {28'h0, st[k]}, 32'd0);
            check_val("rst_err", {31'h0, er[k]}, 32'd0);
        end

        run_suite(0);
        run_suite(1);

        // Abort an iterative op with reset part-way through CALC.
        @(negedge clk);
        iv[0] = 1'b1; op_s[0] = 4'h9; a_s[0] = 32'hDEADBEEF; b_s[0] = 32'h12345678;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (5) @(negedge clk);
        check_val("abort_busy", {31'h0, ir[0]}, 32'd0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        check_val("abort_no_out", {31'h0, seen}, 32'd0);
        check_val("abort_idle", {31'h0, ir[0]}, 32'd1);
        check_val("abort_result", res32, 32'd0);
        run_op(0, 4'h0, 32'd2, 32'd3, 0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
